// File: rtl/rhythm_note_lane_if.sv
// Key inputs and renderer/score outputs of one note lane.
// slave: the lane itself; master: whatever drives keys and consumes results.
interface rhythm_note_lane_if;
  logic [7:0] keycode;
  logic [7:0] keycode_second;
  logic [9:0] noteX;
  logic [9:0] noteY;
  logic       visible;
  logic       hit;
  logic       perfect;
  logic       miss;
  logic       hit_pulse;
  logic [1:0] points;
  logic       done;

  modport slave (
    input  keycode, keycode_second,
    output noteX, noteY, visible, hit, perfect, miss, hit_pulse, points, done
  );

  modport master (
    output keycode, keycode_second,
    input  noteX, noteY, visible, hit, perfect, miss, hit_pulse, points, done
  );
endinterface

// File: rtl/rhythm_note_lane.sv
// Single-lane note dropper: delay after start key, fall, judge the lane key press.
// state   | meaning
// HALTED  | idle at Y_START, waiting for START_KEY
// DELAY   | counting START_DELAY+1 frames before the fall
// FALL    | note visible and moving, press judged each frame
// HIT     | judged hit, results held until RESET_KEY
// MISS    | note reached miss line, results held until RESET_KEY
module rhythm_note_lane #(
  parameter logic [9:0]  X_POS       = 10'd500,
  parameter logic [9:0]  Y_START     = 10'd100,
  parameter logic [9:0]  Y_MAX       = 10'd400,
  parameter logic [9:0]  NOTE_H      = 10'd40,
  parameter logic [3:0]  SPEED       = 4'd1,
  parameter logic [11:0] START_DELAY = 12'd2420,
  parameter logic [9:0]  HIT_LO      = 10'd340,
  parameter logic [9:0]  PERF_LO     = 10'd360,
  parameter logic [9:0]  PERF_HI     = 10'd380,
  parameter logic [7:0]  LANE_KEY    = 8'h4f,
  parameter logic [7:0]  START_KEY   = 8'h2c,
  parameter logic [7:0]  RESET_KEY   = 8'h01
) (
  input  logic              frame_clk,
  input  logic              Reset,
  rhythm_note_lane_if.slave bus
);

  typedef enum logic [2:0] {
    S_HALTED = 3'd0,
    S_DELAY  = 3'd1,
    S_FALL   = 3'd2,
    S_HIT    = 3'd3,
    S_MISS   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  note_y_q, note_y_d;
  logic [11:0] cnt_q, cnt_d;
  logic        press_prev_q, press_prev_d;
  logic        visible_q, visible_d;
  logic        hit_q, hit_d;
  logic        perfect_q, perfect_d;
  logic        miss_q, miss_d;
  logic        hit_pulse_q, hit_pulse_d;
  logic [1:0]  points_q, points_d;
  logic        done_q, done_d;

  logic        press, press_edge;
  logic [10:0] bottom, y_step;
  logic [9:0]  y_limit;
  logic        hit_now, in_perfect, miss_now;

  assign press      = (bus.keycode == LANE_KEY) || (bus.keycode_second == LANE_KEY);
  assign press_edge = press & ~press_prev_q;
  assign bottom     = {1'b0, note_y_q} + {1'b0, NOTE_H};
  assign y_step     = {1'b0, note_y_q} + {7'b0, SPEED};
  assign y_limit    = Y_MAX - NOTE_H;
  assign miss_now   = bottom >= {1'b0, Y_MAX};
  assign hit_now    = press_edge && (bottom >= {1'b0, HIT_LO}) && !miss_now;
  assign in_perfect = (bottom >= {1'b0, PERF_LO}) && (bottom <= {1'b0, PERF_HI});

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q      <= S_HALTED;
      note_y_q     <= Y_START;
      cnt_q        <= '0;
      press_prev_q <= 1'b0;
      visible_q    <= 1'b0;
      hit_q        <= 1'b0;
      perfect_q    <= 1'b0;
      miss_q       <= 1'b0;
      hit_pulse_q  <= 1'b0;
      points_q     <= 2'd0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      note_y_q     <= note_y_d;
      cnt_q        <= cnt_d;
      press_prev_q <= press_prev_d;
      visible_q    <= visible_d;
      hit_q        <= hit_d;
      perfect_q    <= perfect_d;
      miss_q       <= miss_d;
      hit_pulse_q  <= hit_pulse_d;
      points_q     <= points_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HALTED: if (bus.keycode == START_KEY) state_d = S_DELAY;
      S_DELAY:  if (cnt_q >= START_DELAY) state_d = S_FALL;
      S_FALL: begin
        if (hit_now)       state_d = S_HIT;
        else if (miss_now) state_d = S_MISS;
      end
      S_HIT, S_MISS: if (bus.keycode == RESET_KEY) state_d = S_HALTED;
      default: state_d = S_HALTED;
    endcase
  end

  // Registered outputs: everything below is the value seen after the edge.
  always_comb begin
    note_y_d     = note_y_q;
    cnt_d        = cnt_q;
    press_prev_d = press;
    hit_d        = hit_q;
    perfect_d    = perfect_q;
    miss_d       = miss_q;
    points_d     = points_q;
    hit_pulse_d  = 1'b0;
    visible_d    = (state_d == S_FALL);
    done_d       = (state_d == S_HIT) || (state_d == S_MISS);
    case (state_q)
      S_DELAY: if (cnt_q < START_DELAY) cnt_d = cnt_q + 12'd1;
      S_FALL: begin
        if (hit_now) begin
          hit_d       = 1'b1;
          hit_pulse_d = 1'b1;
          perfect_d   = in_perfect;
          points_d    = in_perfect ? 2'd2 : 2'd1;
        end else if (miss_now) begin
          miss_d      = 1'b1;
          hit_pulse_d = 1'b1;
          points_d    = 2'd0;
        end else begin
          note_y_d = (y_step > {1'b0, y_limit}) ? y_limit : y_step[9:0];
        end
      end
      S_HIT, S_MISS: begin
        if (state_d == S_HALTED) begin
          note_y_d  = Y_START;
          cnt_d     = '0;
          hit_d     = 1'b0;
          perfect_d = 1'b0;
          miss_d    = 1'b0;
          points_d  = 2'd0;
        end
      end
      default: begin
        note_y_d  = Y_START;
        cnt_d     = '0;
        hit_d     = 1'b0;
        perfect_d = 1'b0;
        miss_d    = 1'b0;
        points_d  = 2'd0;
      end
    endcase
  end

  assign bus.noteX     = X_POS;
  assign bus.noteY     = note_y_q;
  assign bus.visible   = visible_q;
  assign bus.hit       = hit_q;
  assign bus.perfect   = perfect_q;
  assign bus.miss      = miss_q;
  assign bus.hit_pulse = hit_pulse_q;
  assign bus.points    = points_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_rhythm_note_lane.sv
// Bench for rhythm_note_lane: directed test-plan runs plus random keys, two lanes
// (SPEED 1 and 7) compared every frame against a frame-level game model.
module tb_rhythm_note_lane;

  localparam logic [7:0] LANE  = 8'h4f;
  localparam logic [7:0] START = 8'h2c;
  localparam logic [7:0] RKEY  = 8'h01;
  localparam int DLY = 4;
  localparam int IDLE = 0, WAIT = 1, FALLING = 2, GOT_HIT = 3, GOT_MISS = 4;

  logic frame_clk;
  logic Reset;

  rhythm_note_lane_if ifa ();
  rhythm_note_lane_if ifb ();

  rhythm_note_lane #(.START_DELAY(12'd4)) dut_a (
    .frame_clk(frame_clk), .Reset(Reset), .bus(ifa));
  rhythm_note_lane #(.START_DELAY(12'd4), .SPEED(4'd7)) dut_b (
    .frame_clk(frame_clk), .Reset(Reset), .bus(ifb));

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  int n_total = 0;
  int n_bad   = 0;

  // reference model, one slot per lane
  int m_ph[2], m_wait[2], m_y[2], m_pts[2];
  bit m_hit[2], m_perf[2], m_miss[2], m_pulse[2], m_prev[2];
  int spd[2] = '{1, 7};

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_results(input int i);
    m_y[i] = 100; m_hit[i] = 0; m_perf[i] = 0; m_miss[i] = 0; m_pts[i] = 0;
  endtask

  task automatic model_step(input int i, input bit rst, input logic [7:0] k1, input logic [7:0] k2);
    bit press, pedge;
    int bot;
    if (rst) begin
      m_ph[i] = IDLE; m_wait[i] = 0; m_prev[i] = 0; m_pulse[i] = 0;
      clear_results(i);
      return;
    end
    press = (k1 == LANE) || (k2 == LANE);
    pedge = press && !m_prev[i];
    m_prev[i] = press;
    m_pulse[i] = 0;
    case (m_ph[i])
      IDLE: begin
        clear_results(i);
        if (k1 == START) begin m_ph[i] = WAIT; m_wait[i] = 0; end
      end
      WAIT: begin
        if (m_wait[i] == DLY) m_ph[i] = FALLING;
        else m_wait[i]++;
      end
      FALLING: begin
        bot = m_y[i] + 40;
        if (pedge && bot >= 340 && bot < 400) begin
          m_ph[i] = GOT_HIT; m_hit[i] = 1; m_pulse[i] = 1;
          m_perf[i] = (bot >= 360 && bot <= 380);
          m_pts[i] = m_perf[i] ? 2 : 1;
        end else if (bot >= 400) begin
          m_ph[i] = GOT_MISS; m_miss[i] = 1; m_pulse[i] = 1; m_pts[i] = 0;
        end else begin
          m_y[i] = (m_y[i] + spd[i] > 360) ? 360 : m_y[i] + spd[i];
        end
      end
      default: begin
        if (k1 == RKEY) begin m_ph[i] = IDLE; m_wait[i] = 0; clear_results(i); end
      end
    endcase
  endtask

  task automatic check_lane(input int i, input int nx, input int ny, input int vis, input int h,
                            input int p, input int m, input int hp, input int pts, input int dn);
    chk($sformatf("lane%0d_noteX", i), nx, 500);
    chk($sformatf("lane%0d_noteY", i), ny, m_y[i]);
    chk($sformatf("lane%0d_visible", i), vis, int'(m_ph[i] == FALLING));
    chk($sformatf("lane%0d_hit", i), h, int'(m_hit[i]));
    chk($sformatf("lane%0d_perfect", i), p, int'(m_perf[i]));
    chk($sformatf("lane%0d_miss", i), m, int'(m_miss[i]));
    chk($sformatf("lane%0d_hit_pulse", i), hp, int'(m_pulse[i]));
    chk($sformatf("lane%0d_points", i), pts, m_pts[i]);
    chk($sformatf("lane%0d_done", i), dn, int'(m_ph[i] >= GOT_HIT));
  endtask

  task automatic frame(input bit rst, input logic [7:0] k1, input logic [7:0] k2);
    Reset = rst;
    ifa.keycode = k1; ifa.keycode_second = k2;
    ifb.keycode = k1; ifb.keycode_second = k2;
    @(posedge frame_clk);
    model_step(0, rst, k1, k2);
    model_step(1, rst, k1, k2);
    @(negedge frame_clk);
    check_lane(0, ifa.noteX, ifa.noteY, ifa.visible, ifa.hit, ifa.perfect, ifa.miss,
               ifa.hit_pulse, ifa.points, ifa.done);
    check_lane(1, ifb.noteX, ifb.noteY, ifb.visible, ifb.hit, ifb.perfect, ifb.miss,
               ifb.hit_pulse, ifb.points, ifb.done);
    chk("lane1_clamp", int'(ifb.noteY <= 10'd360), 1);
  endtask

  task automatic run_to_y(input int y);
    for (int n = 0; n < 1000 && !(m_ph[0] == FALLING && m_y[0] == y); n++) frame(0, 8'h00, 8'h00);
    chk("reach_noteY", ifa.noteY, y);
  endtask

  task automatic run_to_end(input int i, input logic [7:0] k1);
    for (int n = 0; n < 1000 && m_ph[i] < GOT_HIT; n++) frame(0, k1, 8'h00);
    chk("reach_done", int'(i == 0 ? ifa.done : ifb.done), 1);
  endtask

  task automatic restart();
    frame(1, 8'h00, 8'h00);
    frame(0, START, 8'h00);
  endtask

  initial begin
    logic [7:0] k1, k2;
    int r;
    Reset = 1'b1;
    ifa.keycode = 8'h00; ifa.keycode_second = 8'h00;
    ifb.keycode = 8'h00; ifb.keycode_second = 8'h00;
    for (int i = 0; i < 2; i++) begin
      m_ph[i] = IDLE; m_wait[i] = 0; m_prev[i] = 0; m_pulse[i] = 0; clear_results(i);
    end
    @(negedge frame_clk);

    frame(1, 8'h00, 8'h00);
    frame(0, 8'h00, 8'h00);
    chk("rst_noteY", ifa.noteY, 100);
    chk("rst_visible", ifa.visible, 0);

    // start, full delay, fall to a miss
    frame(0, START, 8'h00);
    for (int n = 0; n < 4; n++) frame(0, 8'h00, 8'h00);
    chk("delay_visible", ifa.visible, 0);
    frame(0, 8'h00, 8'h00);
    chk("fall_visible", ifa.visible, 1);
    chk("fall_noteY0", ifa.noteY, 100);
    frame(0, 8'h00, 8'h00);
    chk("fall_noteY1", ifa.noteY, 101);
    run_to_end(0, 8'h00);
    chk("miss_flag", ifa.miss, 1);
    chk("miss_pulse", ifa.hit_pulse, 1);
    chk("miss_noteY", ifa.noteY, 360);
    frame(0, 8'h00, 8'h00);
    chk("miss_pulse_off", ifa.hit_pulse, 0);
    chk("miss_done", ifa.done, 1);
    frame(0, RKEY, 8'h00);
    chk("rearm_noteY", ifa.noteY, 100);
    chk("rearm_miss", ifa.miss, 0);

    // perfect and good presses on the secondary slot
    restart();
    run_to_y(330);
    frame(0, 8'h00, LANE);
    chk("perf_flag", ifa.perfect, 1);
    chk("perf_points", ifa.points, 2);
    frame(0, 8'h00, 8'h00);
    restart();
    run_to_y(305);
    frame(0, 8'h00, LANE);
    chk("good_hit", ifa.hit, 1);
    chk("good_points", ifa.points, 1);
    frame(0, 8'h00, 8'h00);

    // held key never counts; release and re-press does
    restart();
    run_to_y(250);
    run_to_end(0, LANE);
    chk("hold_miss", ifa.miss, 1);
    chk("hold_hit", ifa.hit, 0);
    restart();
    run_to_y(250);
    frame(0, LANE, 8'h00);
    frame(0, 8'h00, 8'h00);
    run_to_y(320);
    frame(0, LANE, 8'h00);
    chk("repress_points", ifa.points, 2);

    // fast lane clamps at 360 and misses
    restart();
    run_to_end(1, 8'h00);
    chk("fast_noteY", ifb.noteY, 360);
    chk("fast_miss", ifb.miss, 1);

    // reset mid-fall restarts everything
    restart();
    run_to_y(200);
    frame(1, 8'h00, 8'h00);
    chk("midrst_noteY", ifa.noteY, 100);
    chk("midrst_visible", ifa.visible, 0);
    frame(0, START, 8'h00);
    for (int n = 0; n < 4; n++) frame(0, 8'h00, 8'h00);
    chk("midrst_delay", ifa.visible, 0);
    frame(0, 8'h00, 8'h00);
    chk("midrst_fall", ifa.visible, 1);

    // random keys
    for (int n = 0; n < 4000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      k1 = 8'h00;
      else if (r < 80) k1 = LANE;
      else if (r < 88) k1 = START;
      else if (r < 93) k1 = RKEY;
      else             k1 = 8'($urandom);
      k2 = ($urandom_range(0, 99) < 15) ? LANE : 8'($urandom_range(0, 3));
      frame($urandom_range(0, 299) == 0, k1, k2);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
